// File: rtl/pipe_stall_if.sv
// Front-end hazard/redirect bus between the pipeline control logic,
// instruction memory, decoder and the stall unit.
interface pipe_stall_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              pc_stall;
  logic              IFID_stall;
  logic              IDEX_flush;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump;
  logic [31:0]       jump_target;
  logic [31:0]       imem_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              cnt_clr;
  logic [31:0]       pc;
  logic [31:0]       ifid_instr;
  logic [31:0]       ifid_pc4;
  logic              ifid_valid;
  logic [CTRL_W-1:0] idex_ctrl;
  logic              idex_valid;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output pc_stall, IFID_stall, IDEX_flush,
    output branch_taken, branch_target,
    output jump, jump_target,
    output imem_instr, id_ctrl, cnt_clr,
    input  pc, ifid_instr, ifid_pc4, ifid_valid,
    input  idex_ctrl, idex_valid, stall_cnt
  );

  modport slave (
    input  pc_stall, IFID_stall, IDEX_flush,
    input  branch_taken, branch_target,
    input  jump, jump_target,
    input  imem_instr, id_ctrl, cnt_clr,
    output pc, ifid_instr, ifid_pc4, ifid_valid,
    output idex_ctrl, idex_valid, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_unit.sv
// PC, IF/ID and ID/EX-control registers with load-use stall, flush,
// ID-stage redirect and a saturating stall-cycle counter.
module pipe_stall_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 16,
  parameter int          CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_stall_if.slave   ps
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } id_ex_t;

  logic [31:0]      pc_q, pc_d, pc4;
  if_id_t           ifid_q, ifid_d;
  id_ex_t           idex_q, idex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redir;
  logic             do_jump, do_br, do_seq;

  assign pc4   = pc_q + 32'd4;
  assign redir = (ps.jump | ps.branch_taken) & ~ps.IFID_stall;

  // one-hot next-pc selects, priority folded into the terms
  assign do_jump = ~ps.pc_stall & ps.jump & ~ps.IFID_stall;
  assign do_br   = ~ps.pc_stall & ~ps.jump
                 & ps.branch_taken & ~ps.IFID_stall;
  assign do_seq  = ~ps.pc_stall & ~redir;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      ps.pc_stall: pc_d = pc_q;
      do_jump:     pc_d = ps.jump_target;
      do_br:       pc_d = ps.branch_target;
      do_seq:      pc_d = pc4;
      default:     pc_d = pc_q;
    endcase
  end

  always_comb begin
    ifid_d = ifid_q;
    if (ps.IFID_stall) begin
      ifid_d = ifid_q;
    end else if (redir) begin
      ifid_d = '0;
    end else begin
      ifid_d.instr = ps.imem_instr;
      ifid_d.pc4   = pc4;
      ifid_d.valid = 1'b1;
    end
  end

  always_comb begin
    idex_d = '0;
    if (!ps.IDEX_flush && ifid_q.valid) begin
      idex_d.ctrl  = ps.id_ctrl;
      idex_d.valid = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ps.cnt_clr) begin
      cnt_d = '0;
    end else if (ps.pc_stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ps.pc         = pc_q;
  assign ps.ifid_instr = ifid_q.instr;
  assign ps.ifid_pc4   = ifid_q.pc4;
  assign ps.ifid_valid = ifid_q.valid;
  assign ps.idex_ctrl  = idex_q.ctrl;
  assign ps.idex_valid = idex_q.valid;
  assign ps.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_stall_unit.sv
// Directed bench for pipe_stall_unit: reset, load-use, redirect,
// stall-vs-branch, jump priority, pc wrap and counter saturation.
module tb_pipe_stall_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_stall_if #(.CTRL_W(16), .CNT_W(16)) ps ();

  pipe_stall_unit #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (16),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ps.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pc 4 holds the load-dependent instruction, others are tagged by address
  assign ps.imem_instr = (ps.pc == 32'h4) ? 32'h0128_5020
                                          : {16'hC0DE, ps.pc[15:0]};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ps.pc_stall      = 1'b0;
    ps.IFID_stall    = 1'b0;
    ps.IDEX_flush    = 1'b0;
    ps.branch_taken  = 1'b0;
    ps.branch_target = 32'h0;
    ps.jump          = 1'b0;
    ps.jump_target   = 32'h0;
    ps.id_ctrl       = 16'hBEEF;
    ps.cnt_clr       = 1'b0;

    // reset must act before any clock edge
    #2;
    check("rst_pc", ps.pc, 32'h0);
    check("rst_ifv", {31'b0, ps.ifid_valid}, 32'h0);
    check("rst_ifi", ps.ifid_instr, 32'h0);
    check("rst_ifp", ps.ifid_pc4, 32'h0);
    check("rst_ctl", {16'b0, ps.idex_ctrl}, 32'h0);
    check("rst_exv", {31'b0, ps.idex_valid}, 32'h0);
    check("rst_cnt", {16'b0, ps.stall_cnt}, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("seq_pc0", ps.pc, 32'h0);
    step();
    check("seq_pc4", ps.pc, 32'h4);
    check("seq_ifi0", ps.ifid_instr, 32'hC0DE_0000);
    check("seq_ifp0", ps.ifid_pc4, 32'h4);
    check("seq_exv0", {31'b0, ps.idex_valid}, 32'h0);
    step();
    check("seq_pc8", ps.pc, 32'h8);
    check("seq_ifi4", ps.ifid_instr, 32'h0128_5020);
    check("seq_ctl", {16'b0, ps.idex_ctrl}, 32'h0000_BEEF);
    check("seq_exv1", {31'b0, ps.idex_valid}, 32'h1);

    // load-use bubble at pc=8
    ps.pc_stall   = 1'b1;
    ps.IFID_stall = 1'b1;
    ps.IDEX_flush = 1'b1;
    step();
    ps.pc_stall   = 1'b0;
    ps.IFID_stall = 1'b0;
    ps.IDEX_flush = 1'b0;
    check("lu_pc", ps.pc, 32'h8);
    check("lu_ifi", ps.ifid_instr, 32'h0128_5020);
    check("lu_ifp", ps.ifid_pc4, 32'h8);
    check("lu_ctl", {16'b0, ps.idex_ctrl}, 32'h0);
    check("lu_exv", {31'b0, ps.idex_valid}, 32'h0);
    check("lu_cnt", {16'b0, ps.stall_cnt}, 32'h1);
    step();
    check("lu_pc12", ps.pc, 32'hC);
    check("lu_ifi8", ps.ifid_instr, 32'hC0DE_0008);
    check("lu_exv1", {31'b0, ps.idex_valid}, 32'h1);

    // taken branch at pc=12
    ps.branch_taken  = 1'b1;
    ps.branch_target = 32'h40;
    step();
    ps.branch_taken  = 1'b0;
    check("br_pc", ps.pc, 32'h40);
    check("br_ifv", {31'b0, ps.ifid_valid}, 32'h0);
    check("br_ifi", ps.ifid_instr, 32'h0);
    step();
    check("br_pc44", ps.pc, 32'h44);
    check("br_ifv1", {31'b0, ps.ifid_valid}, 32'h1);
    check("br_ifi40", ps.ifid_instr, 32'hC0DE_0040);
    check("br_exv", {31'b0, ps.idex_valid}, 32'h0);

    // stall suppresses a simultaneous branch
    ps.branch_taken  = 1'b1;
    ps.branch_target = 32'h80;
    ps.pc_stall      = 1'b1;
    ps.IFID_stall    = 1'b1;
    step();
    ps.pc_stall   = 1'b0;
    ps.IFID_stall = 1'b0;
    check("sb_pc", ps.pc, 32'h44);
    check("sb_ifi", ps.ifid_instr, 32'hC0DE_0040);
    check("sb_ifv", {31'b0, ps.ifid_valid}, 32'h1);
    check("sb_cnt", {16'b0, ps.stall_cnt}, 32'h2);
    step();
    ps.branch_taken = 1'b0;
    check("sb_pc80", ps.pc, 32'h80);
    check("sb_ifv0", {31'b0, ps.ifid_valid}, 32'h0);
    step();
    check("sb_pc84", ps.pc, 32'h84);

    // jump wins over branch
    ps.jump          = 1'b1;
    ps.jump_target   = 32'h100;
    ps.branch_taken  = 1'b1;
    ps.branch_target = 32'h200;
    step();
    ps.branch_taken = 1'b0;
    check("jb_pc", ps.pc, 32'h100);
    check("jb_ifv", {31'b0, ps.ifid_valid}, 32'h0);

    // wrap from the top of the address space
    ps.jump_target = 32'hFFFF_FFFC;
    step();
    ps.jump = 1'b0;
    check("wr_pcf", ps.pc, 32'hFFFF_FFFC);
    step();
    check("wr_pc0", ps.pc, 32'h0);
    check("wr_ifp", ps.ifid_pc4, 32'h0);
    check("wr_ifi", ps.ifid_instr, 32'hC0DE_FFFC);

    // counter saturation (already at 2)
    ps.pc_stall = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_cnt", {16'b0, ps.stall_cnt}, 32'h0000_FFFF);
    check("sat_pc", ps.pc, 32'h0);
    step();
    check("sat_hold", {16'b0, ps.stall_cnt}, 32'h0000_FFFF);
    ps.cnt_clr = 1'b1;
    step();
    check("clr_cnt", {16'b0, ps.stall_cnt}, 32'h0);
    ps.cnt_clr  = 1'b0;
    ps.pc_stall = 1'b0;
    step();
    check("clr_hold", {16'b0, ps.stall_cnt}, 32'h0);
    check("clr_pc", ps.pc, 32'h4);

    // reset mid-redirect, asserted between edges
    ps.jump        = 1'b1;
    ps.jump_target = 32'h300;
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc", ps.pc, 32'h0);
    check("ar_ifv", {31'b0, ps.ifid_valid}, 32'h0);
    check("ar_exv", {31'b0, ps.idex_valid}, 32'h0);
    check("ar_ctl", {16'b0, ps.idex_ctrl}, 32'h0);
    ps.jump = 1'b0;
    step();
    check("ar_hold", ps.pc, 32'h0);
    rst_n = 1'b1;
    step();
    check("ar_pc4", ps.pc, 32'h4);
    check("ar_ifi", ps.ifid_instr, 32'hC0DE_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
